fwd_scoreboard_unit: RTL
========================

FWD_SCOREBOARD_UNIT -- requirements
Module: fwd_scoreboard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of ID-stage source operands.
REQ-002 SHALL have parameter NUM_STG, default 2, number of forwarding stages; stage 0 = youngest (MEM), stage 1 = WB.
REQ-003 SHALL have parameter LATE_MIN, default 1, lowest stage index usable by non-early sources.
REQ-004 SHALL have parameter CNT_W, default 8, stall-counter width.
REQ-005 SHALL have parameter TIMEOUT, default 200, stall-cycle watchdog threshold; TIMEOUT SHALL be at most 2^CNT_W-1.
REQ-006 SHALL have the ports below; SW = clog2(NUM_STG+1).
- clk  in  1  single clock; rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_addr  in  NUM_SRC*5  source register numbers.
- src_en  in  NUM_SRC  source i is read this cycle.
- src_early  in  NUM_SRC  source i is consumed in ID (branch/jalr).
- stg_rd  in  NUM_STG*5  destination register per stage.
- stg_wen  in  NUM_STG  stage writes its rd.
- stg_rdy  in  NUM_STG  stage result data is valid (0 = load still outstanding).
- issue_valid  in  1  instruction leaves ID this cycle.
- issue_long  in  1  issued instruction is long-latency (DRAM load, CSR read).
- issue_rd  in  5  its destination.
- long_done  in  1  long-latency result written back this cycle.
- long_rd  in  5  its destination.
- clr_timeout  in  1  clears the timeout flag.
- fwd_sel  out  NUM_SRC*SW  per source: 0 = register file; k = stage k-1.
- stall  out  1  hold ID/IF this cycle.
- pending  out  32  registered scoreboard, one bit per register.
- stall_cnt  out  CNT_W  consecutive stall cycles.
- timeout  out  1  sticky watchdog flag.

Function
REQ-007 Source i SHALL be qualified when src_en[i]=1 and src_addr[i]!=0; an unqualified source SHALL get fwd_sel=0 and SHALL NOT cause a stall.
REQ-008 Stage k SHALL match source i when stg_wen[k]=1, stg_rd[k]!=0, and stg_rd[k]==src_addr[i].
REQ-009 The selected stage SHALL be the lowest-index match, so the youngest producer wins.
REQ-010 Early source: any stage is eligible; fwd_sel = selected k+1.
REQ-011 Non-early source: if the youngest match has k<LATE_MIN, fwd_sel=0 (EX handles it); otherwise fwd_sel = k+1.
REQ-012 fwd_sel SHALL be combinational from the current inputs and registered pending.
REQ-013 stall SHALL assert for an early source whose selected stage has stg_rdy[k]=0.
REQ-014 stall SHALL assert for any qualified source with pending[src_addr]=1 and no matching stage.
REQ-015 A match in any stage SHALL override pending.
REQ-016 long_done SHALL NOT bypass pending in the same cycle; a source reading that register stalls one more cycle.
REQ-017 stall SHALL be combinational; the unit SHALL ignore issue_valid while stall=1.
REQ-018 On a clock edge with issue_valid and issue_long and issue_rd!=0 and stall=0, pending[issue_rd] SHALL be set.
REQ-019 On a clock edge with long_done and long_rd!=0, pending[long_rd] SHALL be cleared.
REQ-020 When set and clear target the same register in the same cycle, set SHALL win.
REQ-021 pending[0] SHALL always be 0.
REQ-022 stall_cnt SHALL increment each cycle stall=1, saturating at 2^CNT_W-1.
REQ-023 stall_cnt SHALL load 0 on the first cycle stall=0.
REQ-024 timeout SHALL set on the edge where stall=1 and stall_cnt==TIMEOUT-1, and SHALL stay set until clr_timeout=1 or reset.
REQ-025 If clr_timeout and the set condition occur together, set SHALL win.

Reset
REQ-026 While rst_n=0: pending=0, stall_cnt=0, timeout=0, asynchronously.
REQ-027 stall and fwd_sel SHALL reflect inputs with the cleared scoreboard, so a reset mid-stall removes scoreboard stalls immediately.
REQ-028 The first state update after rst_n rises SHALL occur on the next clk edge.

Verification
REQ-029 src_addr[0]=5, early=1, stg_rd={5,5}, stg_wen=11, stg_rdy=11 -> fwd_sel[0]=1, stall=0.
REQ-030 Same as REQ-029 but early=0 -> fwd_sel[0]=0; with stg_wen=10 -> fwd_sel[0]=2.
REQ-031 Issue long rd=7, then read r7 with no stage match -> stall=1 until the cycle after long_done rd=7; stall_cnt counts 1,2,... then returns to 0.
REQ-032 Issue long rd=9 and long_done rd=9 on the same edge -> pending[9]=1.
REQ-033 Hold stall 200 cycles -> timeout=1 after the 200th cycle; clr_timeout pulse -> timeout=0.
REQ-034 rst_n low mid-stall with pending[7]=1 -> pending=0, stall_cnt=0, stall=0 without a clock edge.

Source files
------------

// File: rtl/fwd_scoreboard_unit.sv
// Operand forwarding select and long-latency scoreboard for the ID stage; fwd_sel/stall are combinational.
// Scoreboard, stall counter and watchdog update on clk; stall holds issue (issue_valid ignored while stalled).
module fwd_scoreboard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int NUM_STG  = 2,
  parameter int LATE_MIN = 1,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 200
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_SRC*5-1:0]                    src_addr,
  input  logic [NUM_SRC-1:0]                      src_en,
  input  logic [NUM_SRC-1:0]                      src_early,
  input  logic [NUM_STG*5-1:0]                    stg_rd,
  input  logic [NUM_STG-1:0]                      stg_wen,
  input  logic [NUM_STG-1:0]                      stg_rdy,
  input  logic                                    issue_valid,
  input  logic                                    issue_long,
  input  logic [4:0]                              issue_rd,
  input  logic                                    long_done,
  input  logic [4:0]                              long_rd,
  input  logic                                    clr_timeout,
  output logic [NUM_SRC*$clog2(NUM_STG+1)-1:0]    fwd_sel,
  output logic                                    stall,
  output logic [31:0]                             pending,
  output logic [CNT_W-1:0]                        stall_cnt,
  output logic                                    timeout
);

  localparam int SW = $clog2(NUM_STG+1);

  logic [NUM_SRC-1:0] src_stall;
  logic [31:0]        pend_nxt;
  logic               set_p;
  logic               clr_p;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [4:0]    addr;
    logic          qual;
    logic          hit;
    logic          rdy_sel;
    logic [SW-1:0] idx;

    assign addr = src_addr[i*5 +: 5];
    assign qual = src_en[i] && (addr != 5'd0);

    // Descending scan so the youngest (lowest-index) matching stage is what remains.
    always_comb begin
      hit     = 1'b0;
      rdy_sel = 1'b1;
      idx     = '0;
      for (int k = NUM_STG-1; k >= 0; k--) begin
        if (stg_wen[k] && (stg_rd[k*5 +: 5] != 5'd0) && (stg_rd[k*5 +: 5] == addr)) begin
          hit     = 1'b1;
          rdy_sel = stg_rdy[k];
          idx     = SW'(k);
        end
      end
    end

    always_comb begin
      fwd_sel[i*SW +: SW] = '0;
      if (qual && hit && (src_early[i] || (int'(idx) >= LATE_MIN)))
        fwd_sel[i*SW +: SW] = idx + SW'(1);
    end

    assign src_stall[i] = qual && ((src_early[i] && hit && !rdy_sel) ||
                                   (pending[addr] && !hit));
  end

  assign stall = |src_stall;

  assign set_p = issue_valid && issue_long && (issue_rd != 5'd0) && !stall;
  assign clr_p = long_done && (long_rd != 5'd0);

  // Clear first so a same-cycle set on the same register wins.
  always_comb begin
    pend_nxt = pending;
    if (clr_p) pend_nxt[long_rd] = 1'b0;
    if (set_p) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (stall) begin
        if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= '0;
      end
      if (stall && (stall_cnt == CNT_W'(TIMEOUT-1))) timeout <= 1'b1;
      else if (clr_timeout)                          timeout <= 1'b0;
    end
  end

endmodule
